mem_access_unit: RTL and testbench

- Memory-stage sequencer between the EX/MEM pipeline register and the 32-word data memory.
- Accepts one load/store request at a time with byte, halfword or word size.
- Drives the memory's word-addressed read/write controls; sub-word stores run as read-modify-write.
- Returns aligned, sign- or zero-extended load data and stalls the pipeline until each access completes.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage sequencer between the EX/MEM register and a
// word-addressed data memory. Handles byte/halfword/word loads and stores;
// sub-word stores run as a read-modify-write pair. Load results are lane
// extracted and sign/zero extended. Misaligned requests fault without
// touching memory.
// Optional feature: define MAU_BOUNDS_CHECK_EN to fault on any request whose
// address lies beyond the memory; otherwise the word index wraps.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        stall
);

`ifdef MAU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  state_t                 state_q;
  logic [ADDR_BITS+1:0]   addr_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic [31:0]            wdata_q;
  logic [31:0]            merge_q;
  logic [31:0]            load_data_q;
  logic                   load_valid_q;
  logic                   fault_q;

  logic                   req_misalign;
  logic                   req_oob;
  logic                   req_fault;
  logic                   accept;
  logic [31:0]            rd_shifted;
  logic [31:0]            load_data_d;
  logic [31:0]            merge_d;

  // Request decode: alignment/bounds fault, handshake and stall.
  always_comb begin
    req_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    req_oob      = (req_addr[31:ADDR_BITS+2] != '0);
    req_fault    = req_misalign || (BOUNDS_EN && req_oob);
    req_ready    = (state_q == S_IDLE);
    accept       = req_valid && req_ready;
    // A faulting request completes in its accept cycle, so it never stalls.
    stall        = req_valid && (!req_ready || !req_fault);
  end

  // Lane extraction and extension of read data for loads.
  always_comb begin
    rd_shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_data_d = mem_rdata;
    case (size_q)
      2'b00: load_data_d = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                    : {24'h0, rd_shifted[7:0]};
      2'b01: load_data_d = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                    : {16'h0, rd_shifted[15:0]};
      default: load_data_d = mem_rdata;
    endcase
  end

  // Sub-word store merge: replace the target lane of the word read back.
  always_comb begin
    merge_d = merge_q;
    case (size_q)
      2'b00:   merge_d[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_d = wdata_q;
    endcase
  end

  // Memory control decode from state and the latched request; idle drives 0.
  always_comb begin
    mem_read    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write   = (state_q == S_STORE) || (state_q == S_RMW_WR);
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q != S_IDLE)
      mem_address = {{(32-ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};
    if (state_q == S_STORE)
      mem_wdata = wdata_q;
    else if (state_q == S_RMW_WR)
      mem_wdata = merge_d;
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign fault      = fault_q;

  // Sequencer FSM with registered load result and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      merge_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr[ADDR_BITS+1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            if (req_fault)
              fault_q <= 1'b1;
            else if (!req_store)
              state_q <= S_LOAD;
            else if (req_size[1])
              state_q <= S_STORE;
            else
              state_q <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          load_data_q  <= load_data_d;
          load_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_STORE:  state_q <= S_IDLE;
        S_RMW_RD: begin
          merge_q <= mem_rdata;
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic        stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  mem_access_unit #(.ADDR_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Memory writes on the falling edge; reads are combinational.
  always @(negedge clk) begin
    if (mem_write)
      mem[mem_address[4:0]] <= mem_wdata;
    else if (pre_we)
      mem[pre_idx] <= pre_data;
  end
  assign mem_rdata = mem[mem_address[4:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] idx, input logic [31:0] data);
    pre_idx  = idx;
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clk);
    #1;
    pre_we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, sz, sg, a, 32'h0);
    step();
    req_valid = 1'b0;
    chk({tag, "_rd"}, {31'h0, mem_read}, 32'h1);
    step();
    chk({tag, "_vld"}, {31'h0, load_valid}, 32'h1);
    chk({tag, "_data"}, load_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int unsigned i = 0; i < 32; i++) poke(5'(i), 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rd", {31'h0, mem_read}, 32'h0);
    chk("rst_wr", {31'h0, mem_write}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lvld", {31'h0, load_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);

    // Word store 0xDEADBEEF @0x10
    step();
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    #1;
    chk("sw_stall_acc", {31'h0, stall}, 32'h1);
    step();
    req_valid = 1'b0;
    chk("sw_wr", {31'h0, mem_write}, 32'h1);
    chk("sw_rd", {31'h0, mem_read}, 32'h0);
    chk("sw_addr", mem_address, 32'h4);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("sw_done_wr", {31'h0, mem_write}, 32'h0);
    chk("sw_done_ready", {31'h0, req_ready}, 32'h1);
    chk("sw_mem", mem[4], 32'hDEADBEEF);

    // Word load @0x10
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    req_valid = 1'b0;
    chk("lw_rd", {31'h0, mem_read}, 32'h1);
    chk("lw_addr", mem_address, 32'h4);
    chk("lw_early_vld", {31'h0, load_valid}, 32'h0);
    step();
    chk("lw_vld", {31'h0, load_valid}, 32'h1);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_idle_rd", {31'h0, mem_read}, 32'h0);
    step();
    chk("lw_pulse_end", {31'h0, load_valid}, 32'h0);
    chk("lw_hold", load_data, 32'hDEADBEEF);

    // Sub-word loads
    poke(5'd3, 32'h11223344);
    step();
    load_chk("lb_s_0f", 2'b00, 1'b1, 32'h0F, 32'h00000011);
    poke(5'd3, 32'h112233F4);
    step();
    load_chk("lb_s_0c", 2'b00, 1'b1, 32'h0C, 32'hFFFFFFF4);
    step();
    load_chk("lb_u_0c", 2'b00, 1'b0, 32'h0C, 32'h000000F4);
    step();
    load_chk("lh_s_0e", 2'b01, 1'b1, 32'h0E, 32'h00001122);
    poke(5'd5, 32'h80007FFF);
    step();
    load_chk("lh_s_16", 2'b01, 1'b1, 32'h16, 32'hFFFF8000);
    step();
    load_chk("lh_u_16", 2'b01, 1'b0, 32'h16, 32'h00008000);
    step();
    load_chk("lh_s_14", 2'b01, 1'b1, 32'h14, 32'h00007FFF);
    step();
    load_chk("lw_sz11", 2'b11, 1'b1, 32'h10, 32'hDEADBEEF);

    // Halfword store 0xABCD @0x0E via read-modify-write
    poke(5'd3, 32'h11223344);
    step();
    req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFFABCD);
    step();
    req_valid = 1'b0;
    chk("sh_rmwrd_rd", {31'h0, mem_read}, 32'h1);
    chk("sh_rmwrd_wr", {31'h0, mem_write}, 32'h0);
    chk("sh_rmwrd_addr", mem_address, 32'h3);
    chk("sh_rmwrd_ready", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b1;
    #1;
    chk("sh_busy_stall", {31'h0, stall}, 32'h1);
    req_valid = 1'b0;
    step();
    chk("sh_rmwwr_wr", {31'h0, mem_write}, 32'h1);
    chk("sh_rmwwr_rd", {31'h0, mem_read}, 32'h0);
    chk("sh_rmwwr_wdata", mem_wdata, 32'hABCD3344);
    chk("sh_rmwwr_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("sh_done_ready", {31'h0, req_ready}, 32'h1);
    chk("sh_mem", mem[3], 32'hABCD3344);

    // Byte store 0x5A @0x0D
    req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234565A);
    step();
    req_valid = 1'b0;
    step();
    chk("sb_wdata", mem_wdata, 32'hABCD5A44);
    step();
    chk("sb_mem", mem[3], 32'hABCD5A44);

    // Misaligned word load @0x05
    req(1'b0, 2'b10, 1'b0, 32'h05, 32'h0);
    #1;
    chk("flw_stall", {31'h0, stall}, 32'h0);
    step();
    req_valid = 1'b0;
    chk("flw_fault", {31'h0, fault}, 32'h1);
    chk("flw_rd", {31'h0, mem_read}, 32'h0);
    chk("flw_wr", {31'h0, mem_write}, 32'h0);
    chk("flw_ready", {31'h0, req_ready}, 32'h1);
    chk("flw_vld", {31'h0, load_valid}, 32'h0);
    step();
    chk("flw_pulse_end", {31'h0, fault}, 32'h0);
    chk("flw_vld2", {31'h0, load_valid}, 32'h0);
    chk("flw_rd2", {31'h0, mem_read}, 32'h0);

    // Misaligned halfword store @0x03
    req(1'b1, 2'b01, 1'b0, 32'h03, 32'h7777);
    step();
    req_valid = 1'b0;
    chk("fsh_fault", {31'h0, fault}, 32'h1);
    chk("fsh_wr", {31'h0, mem_write}, 32'h0);
    chk("fsh_rd", {31'h0, mem_read}, 32'h0);
    step();
    chk("fsh_pulse_end", {31'h0, fault}, 32'h0);
    chk("fsh_wr2", {31'h0, mem_write}, 32'h0);
    chk("fsh_mem", mem[0], 32'h0);

    // Reset during RMW_RD drops the store
    req(1'b1, 2'b00, 1'b0, 32'h0C, 32'h000000EE);
    step();
    req_valid = 1'b0;
    chk("rrmw_rd", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rrmw_wr", {31'h0, mem_write}, 32'h0);
    chk("rrmw_rd0", {31'h0, mem_read}, 32'h0);
    chk("rrmw_ready", {31'h0, req_ready}, 32'h1);
    chk("rrmw_addr", mem_address, 32'h0);
    chk("rrmw_wdata", mem_wdata, 32'h0);
    chk("rrmw_ldata", load_data, 32'h0);
    chk("rrmw_vld", {31'h0, load_valid}, 32'h0);
    chk("rrmw_fault", {31'h0, fault}, 32'h0);
    chk("rrmw_stall", {31'h0, stall}, 32'h0);
    step();
    chk("rrmw_wr_later", {31'h0, mem_write}, 32'h0);
    chk("rrmw_mem", mem[3], 32'hABCD5A44);

    // Word load @0x84: bounds fault or wrap to word 1
    poke(5'd1, 32'hCAFEF00D);
    step();
    req(1'b0, 2'b10, 1'b0, 32'h84, 32'h0);
    step();
    req_valid = 1'b0;
`ifdef MAU_BOUNDS_CHECK_EN
    chk("oob_fault", {31'h0, fault}, 32'h1);
    chk("oob_rd", {31'h0, mem_read}, 32'h0);
    step();
    chk("oob_vld", {31'h0, load_valid}, 32'h0);
`else
    chk("wrap_rd", {31'h0, mem_read}, 32'h1);
    chk("wrap_addr", mem_address, 32'h1);
    step();
    chk("wrap_vld", {31'h0, load_valid}, 32'h1);
    chk("wrap_data", load_data, 32'hCAFEF00D);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
